// File: rtl/usb_tx_packet_ctrl_if.sv
// TX FIFO side of the USB transmit packet controller: occupancy, head byte and pop strobe.
interface usb_tx_packet_ctrl_if #(
    parameter int OCC_W = 7
);
    logic [OCC_W-1:0] buffer_occupancy;
    logic [7:0]       tx_packet_data;
    logic             get_tx_packet_data;

    // master: the packet controller consuming bytes; slave: the FIFO supplying them
    modport master (input buffer_occupancy, input tx_packet_data, output get_tx_packet_data);
    modport slave  (output buffer_occupancy, output tx_packet_data, input get_tx_packet_data);
endinterface

// File: rtl/usb_tx_packet_ctrl.sv
// USB full-speed TX packet sequencer: SYNC, PID, payload, CRC16, EOP.
// Macro USB_TX_CRC16_EN enables real CRC16; otherwise fixed bytes 0x0D/0x0E are sent.
module usb_tx_packet_ctrl #(
    parameter int OCC_W       = 7,
    parameter int MAX_PAYLOAD = 64
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 bit_strobe,
    input  logic                 byte_done,
    input  logic [2:0]           tx_packet,
    usb_tx_packet_ctrl_if.master fifo,
    output logic                 tx_error,
    output logic                 tx_transfer_active,
    output logic [7:0]           data_out,
    output logic                 pts_enable,
    output logic                 timer_enable,
    output logic                 encoder_enable,
    output logic                 eop_enable
);
    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);

    typedef enum logic [3:0] {
        IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP1, EOP2, EOP3
    } state_t;

    state_t        state, state_n;
    logic [2:0]    pkt_type, pkt_n;
    logic [CW-1:0] count, count_n, cnt_base;
    logic          get_n, err_n, active_n, pts_n, tmr_n, eop_n;
    logic [7:0]    data_n, crc_lo, crc_hi;
    logic          boundary, occ_nz, is_handshake;

    assign boundary     = byte_done & bit_strobe;
    assign occ_nz       = |fifo.buffer_occupancy;
    assign is_handshake = pkt_type inside {3'd2, 3'd3, 3'd4};

    function automatic logic [7:0] pid_byte(input logic [2:0] t);
        case (t)
            3'd1:    pid_byte = 8'hC3;
            3'd2:    pid_byte = 8'hD2;
            3'd3:    pid_byte = 8'h5A;
            3'd4:    pid_byte = 8'h1E;
            3'd5:    pid_byte = 8'h4B;
            default: pid_byte = 8'h00;
        endcase
    endfunction

`ifdef USB_TX_CRC16_EN
    logic [15:0] crc, crc_n, crc_base;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // PID-state boundary seeds the CRC so a zero-length packet closes from 0xFFFF
    assign crc_base = (state == PID) ? 16'hFFFF : crc;
    assign crc_lo   = ~crc_base[7:0];
    assign crc_hi   = ~crc[15:8];
`else
    assign crc_lo = 8'h0D;
    assign crc_hi = 8'h0E;
`endif

    assign cnt_base = (state == PID) ? '0 : count;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state                   <= IDLE;
            pkt_type                <= '0;
            count                   <= '0;
            fifo.get_tx_packet_data <= 1'b0;
            tx_error                <= 1'b0;
            tx_transfer_active      <= 1'b0;
            data_out                <= '0;
            pts_enable              <= 1'b0;
            timer_enable            <= 1'b0;
            encoder_enable          <= 1'b0;
            eop_enable              <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc                     <= '0;
`endif
        end else begin
            state                   <= state_n;
            pkt_type                <= pkt_n;
            count                   <= count_n;
            fifo.get_tx_packet_data <= get_n;
            tx_error                <= err_n;
            tx_transfer_active      <= active_n;
            data_out                <= data_n;
            pts_enable              <= pts_n;
            timer_enable            <= tmr_n;
            encoder_enable          <= tmr_n;
            eop_enable              <= eop_n;
`ifdef USB_TX_CRC16_EN
            crc                     <= crc_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        pkt_n    = pkt_type;
        count_n  = count;
        get_n    = 1'b0;
        err_n    = 1'b0;
        pts_n    = 1'b0;
        data_n   = data_out;
        active_n = tx_transfer_active;
        tmr_n    = timer_enable;
        eop_n    = eop_enable;
`ifdef USB_TX_CRC16_EN
        crc_n    = crc;
`endif
        case (state)
            IDLE: begin
                if (tx_packet inside {[3'd1:3'd5]}) begin
                    pkt_n    = tx_packet;
                    data_n   = 8'h80;
                    pts_n    = 1'b1;
                    active_n = 1'b1;
                    tmr_n    = 1'b1;
                    state_n  = SYNC;
                end else if (tx_packet[2:1] == 2'b11) begin
                    err_n = 1'b1;
                end
            end
            SYNC: if (boundary) begin
                data_n  = pid_byte(pkt_type);
                pts_n   = 1'b1;
                state_n = PID;
            end
            // PID (data types) and DATA share one load rule, seeded via cnt_base/crc_base
            PID, DATA: if (boundary) begin
                if (state == PID && is_handshake) begin
                    eop_n   = 1'b1;
                    state_n = EOP1;
                end else if (occ_nz && cnt_base < MAX_CNT) begin
                    data_n  = fifo.tx_packet_data;
                    pts_n   = 1'b1;
                    get_n   = 1'b1;
                    count_n = cnt_base + CW'(1);
`ifdef USB_TX_CRC16_EN
                    crc_n   = crc16_byte(crc_base, fifo.tx_packet_data);
`endif
                    state_n = DATA;
                end else begin
                    data_n  = crc_lo;
                    pts_n   = 1'b1;
                    count_n = cnt_base;
                    err_n   = occ_nz;
`ifdef USB_TX_CRC16_EN
                    crc_n   = crc_base;
`endif
                    state_n = CRC_LO;
                end
            end
            CRC_LO: if (boundary) begin
                data_n  = crc_hi;
                pts_n   = 1'b1;
                state_n = CRC_HI;
            end
            CRC_HI: if (boundary) begin
                eop_n   = 1'b1;
                state_n = EOP1;
            end
            EOP1: if (bit_strobe) state_n = EOP2;
            EOP2: if (bit_strobe) begin
                eop_n   = 1'b0;
                state_n = EOP3;
            end
            EOP3: if (bit_strobe) begin
                eop_n    = 1'b0;
                tmr_n    = 1'b0;
                active_n = 1'b0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_usb_tx_packet_ctrl.sv
// Directed bench for usb_tx_packet_ctrl: FIFO model, PTS bit counter, byte-sequence checks.
module tb_usb_tx_packet_ctrl;
    localparam int OCC_W = 7;
    localparam int MAXP  = 4;
    localparam int SP    = 4;     // clocks per bit period
    localparam int MAXW  = 4000;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       bit_strobe = 1'b0;
    logic       byte_done;
    logic [2:0] tx_packet;
    logic       tx_error, tx_transfer_active, pts_enable;
    logic       timer_enable, encoder_enable, eop_enable;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    usb_tx_packet_ctrl_if #(.OCC_W(OCC_W)) fif ();

    usb_tx_packet_ctrl #(.OCC_W(OCC_W), .MAX_PAYLOAD(MAXP)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .bit_strobe         (bit_strobe),
        .byte_done          (byte_done),
        .tx_packet          (tx_packet),
        .fifo               (fif.master),
        .tx_error           (tx_error),
        .tx_transfer_active (tx_transfer_active),
        .data_out           (data_out),
        .pts_enable         (pts_enable),
        .timer_enable       (timer_enable),
        .encoder_enable     (encoder_enable),
        .eop_enable         (eop_enable)
    );

    // bit timer and PTS model: byte_done during the 8th bit after each load
    int unsigned sc = 0;
    int unsigned bitcnt = 0;
    always @(posedge clk) begin
        if (sc == SP - 1) begin
            sc         <= 0;
            bit_strobe <= 1'b1;
        end else begin
            sc         <= sc + 1;
            bit_strobe <= 1'b0;
        end
        if (pts_enable)                    bitcnt <= 0;
        else if (bit_strobe && bitcnt != 7) bitcnt <= bitcnt + 1;
    end
    assign byte_done = (bitcnt == 7);

    int total = 0;
    int bad   = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] loads[$];
    logic [7:0] expq[$];
    int n_get, n_get_alone, n_err, n_err_at_load, n_eop, n_en_bad, n_active;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic sync_fifo();
        fif.buffer_occupancy = OCC_W'(fifo_q.size());
        fif.tx_packet_data   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic clear_mon();
        loads.delete();
        n_get = 0; n_get_alone = 0; n_err = 0; n_err_at_load = 0;
        n_eop = 0; n_en_bad = 0; n_active = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (pts_enable) loads.push_back(data_out);
        if (fif.get_tx_packet_data) begin
            n_get++;
            if (!pts_enable) n_get_alone++;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end
        if (tx_error) begin
            n_err++;
            if (pts_enable) n_err_at_load++;
        end
        if (eop_enable) n_eop++;
        if (tx_transfer_active) n_active++;
        if (timer_enable !== tx_transfer_active || encoder_enable !== tx_transfer_active) n_en_bad++;
        sync_fifo();
    endtask

    task automatic start(input string tag, input logic [2:0] t);
        clear_mon();
        tx_packet = t;
        tick();
        tx_packet = 3'd0;
        check({tag, "_start_active"}, tx_transfer_active, 1'b1);
        check({tag, "_start_pts"}, {pts_enable, data_out}, {1'b1, 8'h80});
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (tx_transfer_active === 1'b1 && n < MAXW) begin
            tick();
            n++;
        end
        check({tag, "_done"}, (n < MAXW), 1'b1);
        check({tag, "_eop_len"}, n_eop, 2 * SP);
        check({tag, "_en_consistent"}, n_en_bad, 0);
        check({tag, "_pop_align"}, n_get_alone, 0);
    endtask

    task automatic check_loads(input string tag);
        check({tag, "_nloads"}, loads.size(), expq.size());
        for (int i = 0; i < expq.size() && i < loads.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), loads[i], expq[i]);
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] crc_bytes(input logic [15:0] c);
`ifdef USB_TX_CRC16_EN
        return ~c;
`else
        return (c == 16'h0) ? 16'h0E0D : 16'h0E0D;
`endif
    endfunction

    logic [15:0] c, cb;

    initial begin
        n_rst = 1'b0;
        tx_packet = 3'd0;
        clear_mon();
        sync_fifo();
        tick();
        tick();
        check("reset_outputs",
              {fif.get_tx_packet_data, tx_error, tx_transfer_active, data_out,
               pts_enable, timer_enable, encoder_enable, eop_enable}, '0);
        n_rst = 1'b1;
        repeat (3) tick();

        // ACK, then NAK accepted in the very first IDLE cycle, then STALL
        start("ack", 3'd2);
        wait_done("ack");
        expq = '{8'h80, 8'hD2};
        check_loads("ack");
        check("ack_inactive", tx_transfer_active, 1'b0);
        check("ack_nopop", n_get, 0);
        start("nak", 3'd3);
        wait_done("nak");
        expq = '{8'h80, 8'h5A};
        check_loads("nak");
        start("stall", 3'd4);
        wait_done("stall");
        expq = '{8'h80, 8'h1E};
        check_loads("stall");

        // zero-length DATA0
        cb = crc_bytes(16'hFFFF);
        start("zlp", 3'd1);
        wait_done("zlp");
        expq = '{8'h80, 8'hC3, cb[7:0], cb[15:8]};
        check_loads("zlp");
        check("zlp_nopop", n_get, 0);
        check("zlp_noerr", n_err, 0);

        // DATA1 with exactly MAX_PAYLOAD bytes: no truncation error
        fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        sync_fifo();
        c = 16'hFFFF;
        for (int i = 0; i < 4; i++) c = crc_upd(c, fifo_q[i]);
        cb = crc_bytes(c);
        start("d1", 3'd5);
        wait_done("d1");
        expq = '{8'h80, 8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, cb[7:0], cb[15:8]};
        check_loads("d1");
        check("d1_pops", n_get, 4);
        check("d1_noerr", n_err, 0);
        check("d1_fifo_empty", fifo_q.size(), 0);

        // DATA0 with 6 bytes queued: truncated to 4, one error at the CRC_LO load
        fifo_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        sync_fifo();
        c = 16'hFFFF;
        for (int i = 0; i < 4; i++) c = crc_upd(c, fifo_q[i]);
        cb = crc_bytes(c);
        start("trunc", 3'd1);
        wait_done("trunc");
        expq = '{8'h80, 8'hC3, 8'h10, 8'h11, 8'h12, 8'h13, cb[7:0], cb[15:8]};
        check_loads("trunc");
        check("trunc_pops", n_get, 4);
        check("trunc_err", n_err, 1);
        check("trunc_err_at_crc", n_err_at_load, 1);
        check("trunc_left", fifo_q.size(), 2);
        fifo_q.delete();
        sync_fifo();

        // illegal request codes
        for (int t = 6; t < 8; t++) begin
            clear_mon();
            tx_packet = 3'(t);
            tick();
            tx_packet = 3'd0;
            repeat (30) tick();
            check($sformatf("illegal%0d_err", t), n_err, 1);
            check($sformatf("illegal%0d_noload", t), loads.size(), 0);
            check($sformatf("illegal%0d_inactive", t), n_active, 0);
        end

        // reset in the middle of a DATA1 payload
        fifo_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        sync_fifo();
        begin
            int n = 0;
            start("mid", 3'd5);
            while (n_get < 2 && n < MAXW) begin
                tick();
                n++;
            end
            check("mid_reached_data", (n < MAXW), 1'b1);
        end
        n_rst = 1'b0;
        tick();
        check("mid_reset_outputs",
              {fif.get_tx_packet_data, tx_error, tx_transfer_active, data_out,
               pts_enable, timer_enable, encoder_enable, eop_enable}, '0);
        tick();
        n_rst = 1'b1;
        clear_mon();
        repeat (80) tick();
        check("mid_no_resume", n_active, 0);
        check("mid_no_eop", n_eop, 0);
        check("mid_no_loads", loads.size(), 0);
        fifo_q.delete();
        sync_fifo();

        // controller back in IDLE after the abort
        start("ack2", 3'd2);
        wait_done("ack2");
        expq = '{8'h80, 8'hD2};
        check_loads("ack2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/usb_tx_packet_ctrl.md
# usb_tx_packet_ctrl

Parametrised USB full-speed transmit packet controller. It sits between the TX data FIFO and the serializer chain (PTS shift register, NRZI encoder, bit timer, EOP generator) and sequences SYNC, PID, payload, CRC16 and EOP bytes. Compared with the first-generation controller, it adds:
- DATA1 and STALL packets.
- Zero-length and length-capped data packets.
- Overflow error reporting.
- Optional true CRC16 generation.

## Interface
Parameters:
- OCC_W, 7, width of `buffer_occupancy`.
- MAX_PAYLOAD, 64, maximum payload bytes per data packet (1..2^OCC_W-1).

Ports:
- clk  in  1  system clock; single clock domain.
- n_rst  in  1  reset, synchronous, active-low.
- bit_strobe  in  1  one-cycle pulse per USB bit period, from the bit timer.
- byte_done  in  1  PTS has shifted its last bit of the current byte.
- tx_packet  in  3  request: 0 none, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5 DATA1, 6/7 illegal.
- buffer_occupancy  in  OCC_W  TX FIFO byte count.
- tx_packet_data  in  8  TX FIFO head byte.
- get_tx_packet_data  out  1  one-cycle FIFO pop.
- tx_error  out  1  one-cycle error pulse.
- tx_transfer_active  out  1  packet in progress.
- data_out  out  8  byte presented to PTS, LSB sent first.
- pts_enable  out  1  one-cycle load strobe for `data_out`.
- timer_enable, encoder_enable  out  1  high for the whole packet.
- eop_enable  out  1  drive SE0.

## Operation
- All outputs are registered.
- Reset (n_rst low at a clk edge) sets every output to 0, state to IDLE, and clears the byte counter and CRC register. Reset mid-packet aborts the packet immediately; no EOP is sent.
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP1, EOP2, EOP3.
- Boundary event B = byte_done & bit_strobe. Each byte advance happens only on B.

IDLE:
- tx_packet 6/7: tx_error pulses 1 cycle; the controller stays in IDLE.
- tx_packet 1..5: latch the type, then go to SYNC. In the same cycle set data_out=0x80, pts_enable=1, timer_enable=encoder_enable=tx_transfer_active=1.
- tx_packet is ignored outside IDLE.

SYNC, on B: load the PID byte and go to PID. PID bytes: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.

PID, on B:
- Handshake types (ACK, NAK, STALL) go to EOP1 with eop_enable=1.
- Data types set CRC=0xFFFF and count=0, then go to DATA through the load rule below.

DATA load rule, on B:
- If buffer_occupancy≠0 and count<MAX_PAYLOAD: data_out=tx_packet_data, pts_enable=1, get_tx_packet_data=1 in the same cycle, CRC updated with that byte, count+1.
- Otherwise: data_out=CRC low byte, go to CRC_LO.
- If buffer_occupancy≠0 and count==MAX_PAYLOAD: also pulse tx_error. The payload is truncated and the packet still closes normally.

CRC_LO, on B: load the CRC high byte and go to CRC_HI.

CRC_HI, on B: go to EOP1 with eop_enable=1.

EOP sequence:
- EOP1 waits for one bit_strobe, then goes to EOP2.
- EOP2, on bit_strobe: eop_enable=0, go to EOP3 (J state).
- EOP3, on bit_strobe: go to IDLE and clear all enables and tx_transfer_active.

Strobe and counter rules:
- pts_enable is 0 in every cycle that does not load a byte.
- count is $clog2(MAX_PAYLOAD+1) bits wide and never wraps.

## Timing
- Request to first pts_enable: 1 clk.
- Each byte load happens in the clk after the B cycle. `get_tx_packet_data` is coincident with the pts_enable of that byte, and the FIFO head is sampled in the B cycle.
- Zero-length data packets are legal: SYNC, PID, CRC_LO, CRC_HI, EOP.
- EOP duration: eop_enable high for 2 bit periods, followed by 1 J bit period before IDLE.
- A new request is accepted in the first IDLE cycle after EOP3.

## Configuration
Macro USB_TX_CRC16_EN:
- Defined: CRC16 uses poly 0x8005, reflected (update per bit, LSB first: crc = (crc[0]^d)? (crc>>1)^0xA001 : crc>>1), init 0xFFFF. Transmitted bytes are ~crc[7:0] then ~crc[15:8].
- Undefined: the CRC register is removed and fixed bytes 0x0D, 0x0E are sent (legacy behaviour). All other behaviour is identical.

## Test plan
- Reset: hold n_rst low 2 clk mid-DATA → all outputs 0, state IDLE next cycle, no eop_enable.
- tx_packet=2 (ACK) → pts loads 0x80, 0xD2; eop_enable high 2 bit periods; tx_transfer_active low after EOP3.
- tx_packet=1, occupancy 0 (zero-length) → loads 0x80, 0xC3, 0x00, 0x00 with macro; 0x80, 0xC3, 0x0D, 0x0E without; no get_tx_packet_data pulse.
- tx_packet=5, FIFO 0x01..0x04 → 0x4B, four pops coincident with the data loads, CRC bytes matching a software CRC16 model.
- MAX_PAYLOAD=4, FIFO holds 6 bytes → 4 pops, one tx_error pulse at the fifth boundary, CRC over 4 bytes, normal EOP.
- tx_packet=7 in IDLE → tx_error 1 cycle, no pts_enable, tx_transfer_active stays 0.
